if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  IF stage: owns the PC and runs the req/ack handshake to instruction memory.
//  Drives if_pc/if_inst into the IF/ID flip-flop and raises stallreq_if while
//  a fetch is outstanding. Holds a fetched word while the pipe is stalled.
//  Remembers branch redirects from ID until the PC can advance.
//  Flush (exception) redirects override branches and drain in-flight fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (bits [1:0] must be 0)
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   asynchronous, active-low reset
//  stall            in   6   pipeline stall bus from ctrl; stall[0] freezes PC
//  branch_flag_i    in   1   ID resolved a taken branch this cycle
//  branch_target_i  in   32  branch target address
//  flush_i          in   1   exception flush from ctrl
//  new_pc_i         in   32  handler address, valid with flush_i
//  imem_req_o       out  1   fetch request; held high until ack
//  imem_addr_o      out  32  fetch address (= pc), stable while req high
//  imem_ack_i       in   1   memory accepted request; rdata valid this cycle
//  imem_rdata_i     in   32  instruction word
//  if_pc            out  32  PC of instruction presented to IF/ID
//  if_inst          out  32  instruction presented to IF/ID (0 = bubble)
//  stallreq_if      out  1   stall request to ctrl
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, state=BOOT, hold_buf=0, br_pend=0,
//   imem_req_o=0, if_pc=0, if_inst=0, stallreq_if=0.
//  States:
//  - BOOT: one cycle after reset release, then FETCH.
//  - FETCH: imem_req_o=1, imem_addr_o=pc.
//  - HOLD: req=0; word is held in hold_buf.
//  - DRAIN: req=1; waits for an ack and discards it.
//  FETCH, no ack: if_inst=0, if_pc=0, stallreq_if=1.
//  FETCH, ack, stall[0]=NOSTOP:
//   - if_inst=imem_rdata_i, if_pc=pc, stallreq_if=0 (combinational, same cycle).
//   - pc<=next_pc; stay FETCH. Back-to-back fetches: 1 instr/cycle with 0-wait memory.
//  FETCH, ack, stall[0]=STOP: hold_buf<=rdata, go HOLD.
//  HOLD: if_inst=hold_buf, if_pc=pc, stallreq_if=0.
//   - On stall[0]=NOSTOP: pc<=next_pc, go FETCH.
//  next_pc priority:
//   1. br_pend ? br_tgt
//   2. branch_flag_i ? branch_target_i
//   3. pc+4
//  Target bits [1:0] are forced to 0. pc+4 wraps 32'hFFFF_FFFC -> 0.
//  Branch memory:
//   - If branch_flag_i=1 in a cycle where the PC does not advance:
//     br_pend<=1, br_tgt<=branch_target_i.
//   - br_pend clears when the PC advances.
//   - A second branch while br_pend=1 is ignored.
//  Flush (highest priority, any state):
//   - br_pend<=0, hold_buf dropped, outputs forced to 0 that cycle.
//   - FETCH without ack: pc<=new_pc_i, go DRAIN.
//   - FETCH with ack, or BOOT/HOLD: pc<=new_pc_i, go FETCH next cycle.
//  DRAIN:
//   - imem_req_o=1, imem_addr_o=old address latched at flush; stallreq_if=1.
//   - On ack: data discarded, go FETCH (at pc=new_pc_i).
//   - A flush during DRAIN only updates pc.
//  Branch arriving during DRAIN or the flush cycle is ignored.
//  imem_addr_o/req never change while req=1 and ack=0 (protocol rule).
//  Reset mid-fetch: req drops immediately (async); memory must tolerate an abandoned req.
// STRUCTURE
//  const.v additions:
//   - `ResetPC default
//   - `InstAddrBus, `InstBus, `StallBus, `STOP, `NOSTOP, `ZERO_WORD reused
//   - new `RST_N_ENABLE (1'b0)
//  State encoding: localparams inside the module (2 bits).
//  No sub-module; next-PC mux and FSM fit in one file.
// TESTING
//  0-wait mem, no stall -> if_pc 0,4,8,C on consecutive cycles after BOOT.
//  ack delayed 3 cycles at pc=8 -> stallreq_if=1 x3, addr held 8,
//   then if_inst=rdata, if_pc=8.
//  ack at pc=4 with stall=6'b000011 for 2 cycles -> HOLD, if_inst stable;
//   release -> next req addr=8.
//  branch_flag_i=1, target=0x103 while fetch pending
//   -> br_pend set; after ack next addr=0x100.
//  flush_i, new_pc_i=0x80 with fetch at 0x10 un-acked
//   -> DRAIN keeps addr 0x10; ack discarded (if_inst=0); next addr=0x80.
//  rst low mid-FETCH -> req=0, all outputs 0 immediately;
//   release -> BOOT, then addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_pkg
// Purpose : shared constants, types and helpers for the IF (instruction fetch)
//           stage. Mirrors the legacy const.v macros (InstAddrBus, InstBus,
//           StallBus, STOP, NOSTOP, ZERO_WORD, RST_N_ENABLE, ResetPC).
// Ports   : none (package).
// ----------------------------------------------------------------------------
package if_fetch_pkg;

  typedef logic [31:0] inst_addr_t;   // instruction address bus
  typedef logic [31:0] inst_t;        // instruction word bus
  typedef logic [5:0]  stall_bus_t;   // pipeline stall bus from ctrl

  localparam logic       STOP         = 1'b1;
  localparam logic       NOSTOP       = 1'b0;
  localparam logic       RST_N_ENABLE = 1'b0;   // reset is asserted low
  localparam inst_t      ZERO_WORD    = 32'h0000_0000;
  localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;

  // Instructions are word aligned; the two low address bits are always zero.
  function automatic inst_addr_t align_word(input inst_addr_t addr);
    align_word = {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
// Purpose : IF pipeline stage. Owns the PC, runs the req/ack handshake to
//           instruction memory, presents PC/instruction to the IF/ID register,
//           holds a fetched word while the pipe is stalled, remembers branch
//           redirects until the PC can advance, and handles exception flushes
//           (including draining a fetch that was already in flight).
// Ports   :
//   clk              in   clock, all state updates on posedge
//   rst              in   asynchronous reset, active low
//   stall[5:0]       in   ctrl stall bus; stall[0] freezes the PC
//   branch_flag_i    in   ID resolved a taken branch this cycle
//   branch_target_i  in   branch target address
//   flush_i          in   exception flush from ctrl
//   new_pc_i         in   handler address, valid with flush_i
//   imem_req_o       out  fetch request, held until ack
//   imem_addr_o      out  fetch address, stable while req is high
//   imem_ack_i       in   memory accepted request; rdata valid this cycle
//   imem_rdata_i     in   instruction word
//   if_pc            out  PC presented to IF/ID (0 with a bubble)
//   if_inst          out  instruction presented to IF/ID (0 = bubble)
//   stallreq_if      out  stall request to ctrl while a fetch is outstanding
// ----------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state_r;
  inst_addr_t  pc_r;
  inst_addr_t  drain_addr_r;
  inst_t       hold_buf_r;
  logic        br_pend_r;
  inst_addr_t  br_tgt_r;

  logic        advance_s;
  inst_addr_t  next_pc_s;
  logic        unused_s;

  // Only stall[0] matters to this stage.
  assign unused_s = ^stall[5:1];

  // PC advance condition and next-PC priority mux (pending branch first).
  always_comb begin
    advance_s = 1'b0;
    next_pc_s = pc_r + 32'd4;
    if (flush_i) begin
      advance_s = 1'b0;
    end else if (state_r == FETCH) begin
      advance_s = imem_ack_i && (stall[0] == NOSTOP);
    end else if (state_r == HOLD) begin
      advance_s = (stall[0] == NOSTOP);
    end else begin
      advance_s = 1'b0;
    end
    if (br_pend_r) begin
      next_pc_s = br_tgt_r;
    end else if (branch_flag_i) begin
      next_pc_s = align_word(branch_target_i);
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // Memory request and IF/ID-facing outputs, decoded from the current state.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc_r;
    if_pc       = ZERO_WORD;
    if_inst     = ZERO_WORD;
    stallreq_if = 1'b0;
    case (state_r)
      FETCH: begin
        imem_req_o = 1'b1;
        if (flush_i) begin
          stallreq_if = 1'b0;
        end else if (imem_ack_i) begin
          // Word is presented the same cycle it arrives; it also stays stable
          // into HOLD if the pipe is stalled.
          if_inst = imem_rdata_i;
          if_pc   = pc_r;
        end else begin
          stallreq_if = 1'b1;
        end
      end
      HOLD: begin
        if (flush_i) begin
          if_inst = ZERO_WORD;
        end else begin
          if_inst = hold_buf_r;
          if_pc   = pc_r;
        end
      end
      DRAIN: begin
        // pc already points at the handler; keep the abandoned address on
        // the bus until memory acknowledges it.
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_r;
        stallreq_if = !flush_i;
      end
      default: begin
        imem_req_o = 1'b0;
      end
    endcase
  end

  // FSM, PC, hold buffer and branch memory.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_N_ENABLE) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      drain_addr_r <= ZERO_WORD;
      hold_buf_r   <= ZERO_WORD;
      br_pend_r    <= 1'b0;
      br_tgt_r     <= ZERO_WORD;
    end else if (flush_i) begin
      br_pend_r  <= 1'b0;
      hold_buf_r <= ZERO_WORD;
      pc_r       <= align_word(new_pc_i);
      case (state_r)
        FETCH: begin
          if (imem_ack_i) begin
            state_r <= FETCH;
          end else begin
            drain_addr_r <= pc_r;
            state_r      <= DRAIN;
          end
        end
        DRAIN: begin
          state_r <= imem_ack_i ? FETCH : DRAIN;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= FETCH;
        end
        FETCH: begin
          if (imem_ack_i && (stall[0] == STOP)) begin
            hold_buf_r <= imem_rdata_i;
            state_r    <= HOLD;
          end
        end
        HOLD: begin
          if (stall[0] == NOSTOP) begin
            state_r <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack_i) begin
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
      if (advance_s) begin
        pc_r      <= next_pc_s;
        br_pend_r <= 1'b0;
      end else if (branch_flag_i && !br_pend_r && (state_r != DRAIN)) begin
        // First branch wins; later ones before the PC moves are dropped.
        br_pend_r <= 1'b1;
        br_tgt_r  <= align_word(branch_target_i);
      end
    end
  end

endmodule
